mesh_port_arbiter: RTL
======================

Name: mesh_port_arbiter

Overview:
- Round-robin, burst-limited arbiter that shares one mesh router output link between NUM_SRC source FIFOs (the other router ports plus the local terminal).
- Each source presents a FIFO head through a pndng/data/pop handshake.
- The arbiter selects one source, pops its head into a single-entry output register, and exposes the packet downstream with the same pndng/data_out/pop handshake the mesh uses.
- One instance sits per output direction inside each mesh router.

Parameters:
- NUM_SRC, 5, number of requesting sources (N, S, E, W, local).
- pckg_sz, 41, packet width in bits, passed through unmodified.
- BURST, 4, maximum consecutive packets granted to one source before the grant must rotate (≥1).

Ports:
- clk  in  1  clock; all logic on rising edge.
- reset  in  1  synchronous, active-low reset.
- src_pndng  in  NUM_SRC  source i has a packet at its FIFO head.
- src_data  in  NUM_SRC*pckg_sz  head packets; source i occupies bits [i*pckg_sz +: pckg_sz].
- src_pop  out  NUM_SRC  one-hot single-cycle pop to the granted source.
- pndng  out  1  output register holds a valid packet.
- data_out  out  pckg_sz  output register contents.
- pop  in  1  downstream consumes data_out this cycle.
- grant_id  out  $clog2(NUM_SRC)  source index of the packet in the output register.

Behaviour:
- Reset (reset==0 at posedge) forces: pndng=0, data_out=0, grant_id=0, src_pop=0, rr_ptr=0, burst_cnt=0, state=IDLE.
- Reset mid-operation discards the held packet. No pop is issued in the reset cycle.
- src_pop is combinational from registered state and same-cycle inputs. Source FIFOs pop on the same edge the arbiter loads.
- slot_free = !pndng || pop. A pop while pndng==0 is ignored.
- Load: when slot_free and any src_pndng is high, exactly one src_pop[sel] is high for that cycle. On the edge, data_out <= src_data[sel], grant_id <= sel, pndng <= 1.
- Load-to-output latency is 1 cycle. Throughput is 1 packet/cycle when downstream pops every cycle.
- Unload: if pop && !load, pndng <= 0 on the edge. Simultaneous pop and load replaces the register contents; pndng stays 1.
- Stall: when !slot_free, src_pop=0 and data_out/grant_id stay stable.
- State machine:
  - IDLE: no grant held.
    - Any src_pndng && slot_free → select first requester at or after rr_ptr (ascending, wrapping NUM_SRC-1→0).
    - Load it, set owner=sel, burst_cnt=1, go to BURST.
  - BURST: owner holds the grant.
    - When slot_free: if src_pndng[owner] && burst_cnt<BURST, load from owner again and increment burst_cnt.
    - Otherwise (owner empty or burst_cnt==BURST), rr_ptr <= (owner+1) mod NUM_SRC and go to IDLE. If another source is pending, select from the new pointer and load in the same cycle, so rotation never costs a bubble.
    - When !slot_free: hold state.
- burst_cnt is $clog2(BURST+1) bits. It saturates at BURST and never wraps.
- Fairness: with all sources pending, each source waits at most (NUM_SRC-1)*BURST loads between its bursts.
- src_pop is never asserted toward a source whose src_pndng is low.
- Packets are never duplicated or dropped. Order within one source is preserved.

Decomposition:
- Shared package mesh_arb_pkg holds:
  - arbitration state enum (IDLE, BURST);
  - function rr_select(req, ptr) returning the first set bit at or after ptr with wrap, plus a found flag;
  - localparam SRC_W = $clog2(NUM_SRC).
- One natural sub-module: mesh_out_reg, the single-entry pndng/pop output register with load/unload/simultaneous rules.
- Arbiter FSM, burst counter and pointer stay in the top module.

Test Plan:
1. Reset and idle: hold reset=0 for 3 cycles with src_pndng=5'b11111 → src_pop=0, pndng=0, data_out=0 throughout. Release → first src_pop=5'b00001, next cycle pndng=1, grant_id=0.
2. Burst limit: only source 2 pending with 6 packets (0xA0..0xA5), pop tied 1 → 4 consecutive src_pop[2] pulses, data_out 0xA0..0xA3, one-cycle rotation check (IDLE reselects 2, no other requester), then 0xA4, 0xA5. Exactly 6 pops total.
3. Round-robin fairness: all 5 sources always pending, BURST=4, pop tied 1 for 40 cycles → grant_id sequence is 0×4, 1×4, 2×4, 3×4, 4×4, 0×4…, with no bubble on pndng.
4. Backpressure: pop=0 for 10 cycles with sources pending → after the first load, src_pop stays 0 and data_out/grant_id stay stable. Raise pop → one packet per cycle resumes.
5. Owner drains early: source 1 has 2 packets, source 3 has 3 packets, rr_ptr=0 → grants 1, 1, then immediately 3, 3, 3. After that, rr_ptr=4.
6. Reset mid-burst: drop reset while pndng=1 and burst_cnt=2 → next cycle pndng=0 and rr_ptr=0. The held packet is never reported via pop, and arbitration restarts from source 0.

Source files
------------

// File: rtl/mesh_arb_pkg.sv
`default_nettype none
// mesh_arb_pkg: shared state encoding and round-robin scan for the mesh output-port arbiter.
// Rev 1.0
package mesh_arb_pkg;

  localparam int NUM_SRC_DFLT = 5;
  localparam int SRC_W        = $clog2(NUM_SRC_DFLT);
  localparam int RR_MAX       = 16;

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_BURST = 1'b1
  } arb_state_t;

  // Returns the first set bit of req at or after ptr, wrapping at n.
  function automatic int rr_select(input logic [RR_MAX-1:0] req, input int ptr, input int n,
                                   output logic found);
    int idx;
    int j;
    idx   = 0;
    found = 1'b0;
    for (int i = 0; i < RR_MAX; i++) begin
      j = ptr + i;
      if (j >= n) j = j - n;
      if (!found && (i < n) && (j < RR_MAX) && req[j]) begin
        found = 1'b1;
        idx   = j;
      end
    end
    return idx;
  endfunction

endpackage
`default_nettype wire

// File: rtl/mesh_out_reg.sv
`default_nettype none
// mesh_out_reg: single-entry pndng/pop output register; a load wins over a simultaneous unload.
// Rev 1.0
module mesh_out_reg #(
  parameter int W   = 41,
  parameter int IDW = 3
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           load,
  input  logic [W-1:0]   load_data,
  input  logic [IDW-1:0] load_id,
  input  logic           pop,
  output logic           pndng,
  output logic [W-1:0]   data_out,
  output logic [IDW-1:0] grant_id
);

  always_ff @(posedge clk) begin
    if (!reset) begin
      pndng    <= 1'b0;
      data_out <= '0;
      grant_id <= '0;
    end else if (load) begin
      pndng    <= 1'b1;
      data_out <= load_data;
      grant_id <= load_id;
    end else if (pop) begin
      pndng    <= 1'b0;
    end
  end

endmodule
`default_nettype wire

// File: rtl/mesh_port_arbiter.sv
`default_nettype none
// mesh_port_arbiter: round-robin, burst-limited arbiter sharing one mesh output link among NUM_SRC FIFOs.
// Rev 1.0
module mesh_port_arbiter
  import mesh_arb_pkg::*;
#(
  parameter int NUM_SRC = NUM_SRC_DFLT,
  parameter int pckg_sz = 41,
  parameter int BURST   = 4
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [NUM_SRC-1:0]         src_pndng,
  input  logic [NUM_SRC*pckg_sz-1:0] src_data,
  output logic [NUM_SRC-1:0]         src_pop,
  output logic                       pndng,
  output logic [pckg_sz-1:0]         data_out,
  input  logic                       pop,
  output logic [$clog2(NUM_SRC)-1:0] grant_id
);

  localparam int GW = $clog2(NUM_SRC);
  localparam int CW = $clog2(BURST + 1);

  arb_state_t    state;
  logic [GW-1:0] owner;
  logic [GW-1:0] rr_ptr;
  logic [CW-1:0] burst_cnt;

  logic [GW-1:0] owner_nxt;
  logic [GW-1:0] scan_ptr;
  logic [GW-1:0] sel;
  logic          slot_free;
  logic          keep_owner;
  logic          rr_found;
  logic          load;
  int            rr_idx;

  always_comb begin
    owner_nxt  = (owner == GW'(NUM_SRC - 1)) ? '0 : owner + 1'b1;
    slot_free  = !pndng || pop;
    keep_owner = (state == ST_BURST) && src_pndng[owner] && (burst_cnt < CW'(BURST));
    // On rotation the scan starts past the owner, so a new grantee loads in the same cycle.
    scan_ptr   = (state == ST_BURST) ? owner_nxt : rr_ptr;
    rr_idx     = rr_select(RR_MAX'(src_pndng), int'(scan_ptr), NUM_SRC, rr_found);
    sel        = keep_owner ? owner : GW'(rr_idx);
    load       = reset && slot_free && (keep_owner || rr_found);
    src_pop    = '0;
    if (load) src_pop[sel] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state     <= ST_IDLE;
      owner     <= '0;
      rr_ptr    <= '0;
      burst_cnt <= '0;
    end else if (slot_free) begin
      if (keep_owner) begin
        burst_cnt <= burst_cnt + 1'b1;
      end else begin
        if (state == ST_BURST) rr_ptr <= owner_nxt;
        if (rr_found) begin
          state     <= ST_BURST;
          owner     <= sel;
          burst_cnt <= CW'(1);
        end else begin
          state     <= ST_IDLE;
          burst_cnt <= '0;
        end
      end
    end
  end

  mesh_out_reg #(
    .W   (pckg_sz),
    .IDW (GW)
  ) u_out_reg (
    .clk       (clk),
    .reset     (reset),
    .load      (load),
    .load_data (src_data[sel*pckg_sz +: pckg_sz]),
    .load_id   (sel),
    .pop       (pop),
    .pndng     (pndng),
    .data_out  (data_out),
    .grant_id  (grant_id)
  );

endmodule
`default_nettype wire
